// File: rtl/ysyx_22050019_exu_ctrl_pkg.sv
// Shared definitions for the EXU controller.
// Holds the ALU select width macro `LEN, the FSM state encoding and the
// default latency/width parameters.
`ifndef LEN
`define LEN 4
`endif

package ysyx_22050019_exu_ctrl_pkg;

  localparam int SEL_W         = `LEN + 1;
  localparam int DEF_MULTI_LAT = 64;
  localparam int DEF_XLEN      = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_HOLD = ST_HOLD
  } state_e;

  // Counter width for a given latency; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/ysyx_22050019_exu_lat_cnt.sv
// Loadable down-counter with a zero flag, used to time the EXEC phase.
// Load wins over decrement; the counter parks at zero.
module ysyx_22050019_exu_lat_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load a new latency on accept, otherwise count down while executing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ysyx_22050019_exu_ctrl.sv
// EXU sequencer between IDU and WBU.
// Accepts one decoded op per handshake, runs it for 1 or MULTI_LAT cycles,
// then holds the write-back payload until the WBU takes it.
// Optional feature: define YSYX_22050019_EXU_FLUSH_EN to add the flush input.
module ysyx_22050019_exu_ctrl
  import ysyx_22050019_exu_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = DEF_MULTI_LAT,
  parameter int XLEN      = DEF_XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef YSYX_22050019_EXU_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_alu_sel,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic             in_multi,
  input  logic             in_reg_we,
  input  logic [4:0]       in_reg_waddr,
  output logic [SEL_W-1:0] exu_alu_sel,
  output logic [XLEN-1:0]  exu_op1,
  output logic [XLEN-1:0]  exu_op2,
  output logic             exu_first,
  output logic             exu_step,
  input  logic [XLEN-1:0]  exu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_wdata,
  output logic             out_reg_we,
  output logic [4:0]       out_waddr
);

  localparam int               CNT_W      = cnt_width(MULTI_LAT);
  localparam logic [CNT_W-1:0] MULTI_LOAD = CNT_W'(MULTI_LAT - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_flush;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_cnt_zero;
  logic             w_exec_last;
  logic [CNT_W-1:0] w_load_val;

  logic [SEL_W-1:0] r_sel;
  logic [XLEN-1:0]  r_op1;
  logic [XLEN-1:0]  r_op2;
  logic             r_first;
  logic             r_op_we;
  logic [4:0]       r_op_waddr;
  logic [XLEN-1:0]  r_wdata;
  logic             r_out_we;
  logic [4:0]       r_out_waddr;

`ifdef YSYX_22050019_EXU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A HOLD cycle whose payload is being taken can accept the next op directly.
  assign w_in_ready  = ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready)) && !w_flush;
  assign w_accept    = in_valid && w_in_ready;
  assign w_exec_last = (r_state == S_EXEC) && w_cnt_zero && !w_flush;
  assign w_load_val  = in_multi ? MULTI_LOAD : '0;

  ysyx_22050019_exu_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (w_load_val),
    .i_dec      (r_state == S_EXEC),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_EXEC;
      S_EXEC: if (w_cnt_zero) w_state_next = S_HOLD;
      S_HOLD: begin
        if (w_accept) begin
          w_state_next = S_EXEC;
        end else if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_flush) begin
      w_state_next = S_IDLE;
    end
  end

  // Operand latch on accept and write-back capture on the last EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_first     <= 1'b0;
      r_op_we     <= 1'b0;
      r_op_waddr  <= '0;
      r_wdata     <= '0;
      r_out_we    <= 1'b0;
      r_out_waddr <= '0;
    end else begin
      r_first <= w_accept;
      if (w_accept) begin
        r_sel      <= in_alu_sel;
        r_op1      <= in_op1;
        r_op2      <= in_op2;
        r_op_we    <= in_reg_we;
        r_op_waddr <= in_reg_waddr;
      end
      if (w_exec_last) begin
        r_wdata     <= r_op_we ? exu_result : '0;
        r_out_we    <= r_op_we;
        r_out_waddr <= r_op_waddr;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign exu_alu_sel = r_sel;
  assign exu_op1     = r_op1;
  assign exu_op2     = r_op2;
  assign exu_first   = r_first;
  assign exu_step    = (r_state == S_EXEC);
  assign out_valid   = (r_state == S_HOLD);
  assign out_wdata   = r_wdata;
  assign out_reg_we  = r_out_we;
  assign out_waddr   = r_out_waddr;

endmodule
